sprite_line_engine: RTL and testbench

SPRITE_LINE_ENGINE -- requirements
Module: sprite_line_engine

---
 rtl/sprite_pkg.sv | 40 ++++
 rtl/sprite_attr_ram.sv | 24 ++
 rtl/sprite_line_engine.sv | 188 ++++++++++++++++++
 tb/tb_sprite_line_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line engine: screen limits, attribute
// word layout, FSM encoding and the per-line slot record.
package sprite_pkg;

   localparam logic [10:0] SCREEN_W = 11'd640;
   localparam logic [9:0]  SCREEN_H = 10'd480;

   localparam int A_EN     = 31;
   localparam int A_HFLIP  = 30;
   localparam int A_VFLIP  = 29;
   localparam int A_SIZE   = 28;
   localparam int A_RSVD   = 27;
   localparam int A_ROW_HI = 26;
   localparam int A_ROW_LO = 18;
   localparam int A_COL_HI = 17;
   localparam int A_COL_LO = 8;
   localparam int A_FRM_HI = 7;
   localparam int A_FRM_LO = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAW,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic       hflip;
      logic       size;
      logic [4:0] row_off;
      logic [9:0] col;
      logic [7:0] frame;
   } slot_t;

   // Sprite edge length in pixels (sprites are square).
   function automatic logic [5:0] sprite_dim(input logic size);
      return size ? 6'd32 : 6'd16;
   endfunction

endpackage

// File: rtl/sprite_attr_ram.sv
// Sprite attribute RAM: one write port, one synchronous read port.
// A read and write to the same index in one cycle returns the old word.
module sprite_attr_ram #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
      rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/sprite_line_engine.sv
// Renders one screen line of sprites: scans the attribute RAM for hits,
// then fetches pattern pixels from an external ROM into a line buffer.
module sprite_line_engine
   import sprite_pkg::*;
#(
   parameter int          NUM_SPRITE = 32,
   parameter int          MAX_SLOT   = 8,
   parameter int          ROM_AW     = 16,
   parameter logic [15:0] TRANSP_KEY = 16'hF81F
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [9:0]                    target_row,
   input  logic                          spr_wr_en,
   input  logic [$clog2(NUM_SPRITE)-1:0] spr_wr_idx,
   input  logic [31:0]                   spr_wr_data,
   output logic [ROM_AW-1:0]             rom_addr,
   input  logic [15:0]                   rom_q,
   output logic [9:0]                    pixel_col,
   output logic [15:0]                   pixel_data,
   output logic                          pixel_wren,
   output logic                          busy,
   output logic                          done,
   output logic                          overflow
);

   localparam int IW    = $clog2(NUM_SPRITE);
   localparam int SW    = $clog2(MAX_SLOT + 1);
   localparam int PW    = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1;
   localparam int SUM_W = (ROM_AW > 18) ? ROM_AW : 18;

   state_t         state_q, state_d;
   logic [9:0]     row_q;
   logic [IW:0]    scan_cnt;
   logic [SW-1:0]  slot_cnt;
   logic [PW-1:0]  slot_ptr;
   logic [5:0]     x_cnt;
   slot_t          slots [MAX_SLOT];

   logic [31:0]    attr;
   logic           start_ok, scan_last, hit, slot_full, accept;
   logic [9:0]     a_row, a_end, raw_off;
   logic [5:0]     a_h, hm1;
   logic [4:0]     row_off;

   slot_t          cur;
   logic [5:0]     w, xp;
   logic           issue, slot_end, draw_last;
   logic [SUM_W-1:0] addr_sum;
   logic [10:0]    col_sum;
   logic           vld_p1, in_scr_p1;
   logic           unused_bits;

   sprite_attr_ram #(
      .DEPTH (NUM_SPRITE),
      .AW    (IW)
   ) u_attr_ram (
      .clk     (clk),
      .wr_en   (spr_wr_en),
      .wr_idx  (spr_wr_idx),
      .wr_data (spr_wr_data),
      .rd_idx  (scan_cnt[IW-1:0]),
      .rd_data (attr)
   );

   assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
   assign scan_last = (scan_cnt == (IW+1)'(NUM_SPRITE));
   assign busy      = (state_q == ST_SCAN) || (state_q == ST_DRAW);
   assign done      = (state_q == ST_DONE);

   // Scan stage: RAM word for index scan_cnt-1 is on attr this cycle.
   always_comb begin
      a_row     = {1'b0, attr[A_ROW_HI:A_ROW_LO]};
      a_h       = sprite_dim(attr[A_SIZE]);
      a_end     = a_row + {4'b0, a_h};
      hit       = (state_q == ST_SCAN) && (scan_cnt != '0) && attr[A_EN]
                  && (row_q >= a_row) && (row_q < a_end);
      raw_off   = row_q - a_row;
      hm1       = a_h - 6'd1;
      row_off   = attr[A_VFLIP] ? (hm1[4:0] - raw_off[4:0]) : raw_off[4:0];
      slot_full = (slot_cnt == SW'(MAX_SLOT));
      accept    = hit && !slot_full;
   end

   // Draw stage p0: address issue for pixel x_cnt of the current slot.
   always_comb begin
      cur       = slots[slot_ptr];
      w         = sprite_dim(cur.size);
      xp        = cur.hflip ? (w - 6'd1 - x_cnt) : x_cnt;
      issue     = (state_q == ST_DRAW) && (slot_cnt != '0) && (x_cnt < w);
      slot_end  = (x_cnt == w);
      draw_last = (slot_cnt == '0) || (slot_end && slot_ptr == '0);
      addr_sum  = (SUM_W'(cur.frame) << 8) + SUM_W'(cur.row_off) * SUM_W'(w)
                  + SUM_W'(xp);
      col_sum   = {1'b0, cur.col} + {5'b0, x_cnt};
      rom_addr  = issue ? addr_sum[ROM_AW-1:0] : '0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = (target_row >= SCREEN_H) ? ST_DONE : ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (scan_last) state_d = ST_DRAW;
         end
         ST_DRAW: begin
            if (draw_last) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt <= '0;
         slot_cnt <= '0;
         slot_ptr <= '0;
         x_cnt    <= '0;
         overflow <= 1'b0;
      end else if (start_ok) begin
         scan_cnt <= '0;
         slot_cnt <= '0;
         slot_ptr <= '0;
         x_cnt    <= '0;
         overflow <= 1'b0;
      end else if (state_q == ST_SCAN) begin
         scan_cnt <= scan_cnt + 1'b1;
         if (accept) begin
            slot_cnt <= slot_cnt + 1'b1;
            slot_ptr <= slot_cnt[PW-1:0];
         end else if (hit) begin
            overflow <= 1'b1;
         end
      end else if (state_q == ST_DRAW) begin
         x_cnt <= slot_end ? 6'd0 : x_cnt + 6'd1;
         if (slot_end && slot_ptr != '0) begin
            slot_ptr <= slot_ptr - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start_ok) begin
         row_q <= target_row;
      end
      if (accept) begin
         slots[slot_cnt[PW-1:0]] <= '{hflip:   attr[A_HFLIP],
                                      size:    attr[A_SIZE],
                                      row_off: row_off,
                                      col:     attr[A_COL_HI:A_COL_LO],
                                      frame:   attr[A_FRM_HI:A_FRM_LO]};
      end
   end

   // Stage p1: ROM data returns one cycle after its address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1    <= 1'b0;
         in_scr_p1 <= 1'b0;
         pixel_col <= '0;
      end else begin
         vld_p1    <= issue;
         in_scr_p1 <= (col_sum < SCREEN_W);
         if (issue) begin
            pixel_col <= col_sum[9:0];
         end
      end
   end

   assign pixel_wren = vld_p1 && in_scr_p1 && (rom_q != TRANSP_KEY);
   assign pixel_data = vld_p1 ? rom_q : 16'h0000;

   assign unused_bits = ^{attr[A_RSVD], raw_off[9:5], hm1[5], addr_sum};

endmodule

// File: tb/tb_sprite_line_engine.sv
// Scoreboard bench for sprite_line_engine with a line-level reference model
// and a registered pattern ROM model.
module tb_sprite_line_engine;

   localparam int          N   = 32;
   localparam int          MS  = 8;
   localparam logic [15:0] KEY = 16'hF81F;

   logic        clk, reset, start, spr_wr_en;
   logic [9:0]  target_row, pixel_col;
   logic [4:0]  spr_wr_idx;
   logic [31:0] spr_wr_data;
   logic [15:0] rom_addr, rom_q, pixel_data;
   logic        pixel_wren, busy, done, overflow;

   typedef struct {
      logic [9:0]  col;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] attr_m [N];
   logic [15:0] rom_seed;
   logic        transp_on;
   int          n_cmp, n_err;

   sprite_line_engine #(
      .NUM_SPRITE (N),
      .MAX_SLOT   (MS),
      .ROM_AW     (16),
      .TRANSP_KEY (KEY)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .target_row  (target_row),
      .spr_wr_en   (spr_wr_en),
      .spr_wr_idx  (spr_wr_idx),
      .spr_wr_data (spr_wr_data),
      .rom_addr    (rom_addr),
      .rom_q       (rom_q),
      .pixel_col   (pixel_col),
      .pixel_data  (pixel_data),
      .pixel_wren  (pixel_wren),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] rom_fn(input logic [15:0] a);
      if (transp_on && a[3:0] == 4'h5) return KEY;
      return a ^ rom_seed;
   endfunction

   always @(posedge clk) rom_q <= rom_fn(rom_addr);

   function automatic logic [31:0] mk_attr(input logic en, input logic hf, input logic vf,
                                           input logic sz, input int row, input int col,
                                           input int frame);
      logic [8:0] r;
      logic [9:0] c;
      logic [7:0] f;
      r = 9'(row);
      c = 10'(col);
      f = 8'(frame);
      return {en, hf, vf, sz, 1'b0, r, c, f};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (pixel_wren === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL pixel_unexpected: col=%0d data=%h expected no write", pixel_col, pixel_data);
            end else begin
               e = exp_q.pop_front();
               if (pixel_col !== e.col || pixel_data !== e.data) begin
                  n_err++;
                  $display("FAIL pixel: col=%0d data=%h expected col=%0d data=%h",
                           pixel_col, pixel_data, e.col, e.data);
               end
            end
         end
      end
   endtask

   task automatic wr_attr(input int idx, input logic [31:0] d);
      @(negedge clk);
      spr_wr_en   = 1'b1;
      spr_wr_idx  = 5'(idx);
      spr_wr_data = d;
      @(negedge clk);
      spr_wr_en   = 1'b0;
      attr_m[idx] = d;
   endtask

   // Line-level model: collect hits in index order, then emit the visible
   // pixels slot by slot from the last stored hit back to the first.
   task automatic model(input int tr, output int cyc, output logic ovf);
      int          hits[$];
      int          h, w, roff, xp, addr, c, row, d;
      logic [31:0] a;
      logic [15:0] dat;
      exp_t        e;
      ovf = 1'b0;
      cyc = 1;
      if (tr >= 480) return;
      for (int i = 0; i < N; i++) begin
         a   = attr_m[i];
         h   = a[28] ? 32 : 16;
         row = int'(a[26:18]);
         if (a[31] && row <= tr && tr < row + h) begin
            if (hits.size() < MS) hits.push_back(i);
            else begin
               ovf = 1'b1;
               break;
            end
         end
      end
      d = 0;
      for (int s = hits.size() - 1; s >= 0; s--) begin
         a    = attr_m[hits[s]];
         w    = a[28] ? 32 : 16;
         roff = tr - int'(a[26:18]);
         if (a[29]) roff = w - 1 - roff;
         for (int x = 0; x < w; x++) begin
            xp   = a[30] ? (w - 1 - x) : x;
            addr = (int'(a[7:0]) * 256 + roff * w + xp) % 65536;
            c    = int'(a[17:8]) + x;
            dat  = rom_fn(16'(addr));
            if (c < 640 && dat != KEY) begin
               e.col  = 10'(c);
               e.data = dat;
               exp_q.push_back(e);
            end
         end
         d += w + 1;
      end
      if (d == 0) d = 1;
      cyc = N + 2 + d;
   endtask

   task automatic render(input int tr, input string name);
      int   cyc, k;
      logic ovf;
      model(tr, cyc, ovf);
      @(negedge clk);
      target_row = 10'(tr);
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k     = 1;
      while (done !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_cycles"}, 32'(k), 32'(cyc));
      chk({name, "_overflow"}, 32'(overflow), 32'(ovf));
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_missing_pixels"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int k;
      n_cmp       = 0;
      n_err       = 0;
      reset       = 1'b0;
      start       = 1'b0;
      target_row  = '0;
      spr_wr_en   = 1'b0;
      spr_wr_idx  = '0;
      spr_wr_data = '0;
      rom_seed    = 16'h0000;
      transp_on   = 1'b0;
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_done",       32'(done),       32'd0);
      chk("rst_overflow",   32'(overflow),   32'd0);
      chk("rst_wren",       32'(pixel_wren), 32'd0);
      chk("rst_pixel_col",  32'(pixel_col),  32'd0);
      chk("rst_pixel_data", 32'(pixel_data), 32'd0);
      chk("rst_rom_addr",   32'(rom_addr),   32'd0);
      reset = 1'b1;

      for (int i = 0; i < N; i++) wr_attr(i, 32'd0);

      render(500, "offscreen");

      wr_attr(0, mk_attr(1, 0, 0, 0, 100, 200, 3));
      render(105, "single16");

      for (int i = 0; i < N; i++) wr_attr(i, 32'd0);
      wr_attr(0, mk_attr(1, 0, 0, 0, 10, 50, 2));
      wr_attr(1, mk_attr(1, 0, 0, 0, 10, 50, 1));
      render(10, "overlap");

      for (int i = 0; i < 9; i++) wr_attr(i, mk_attr(1, 0, 0, 0, 20, i * 60, i + 16));
      render(20, "nine_hits");

      for (int i = 0; i < N; i++) wr_attr(i, 32'd0);
      wr_attr(0, mk_attr(1, 1, 1, 1, 200, 630, 7));
      render(200, "flip32_edge");

      begin
         int   cyc;
         logic ovf;
         model(200, cyc, ovf);
         @(negedge clk);
         target_row = 10'd200;
         start      = 1'b1;
         @(negedge clk);
         start = 1'b0;
         k     = 0;
         while (pixel_wren !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
         end
         chk("middraw_first_wren_seen", 32'(pixel_wren), 32'd1);
         #2 reset = 1'b0;
         #1;
         chk("middraw_wren",     32'(pixel_wren), 32'd0);
         chk("middraw_busy",     32'(busy),       32'd0);
         chk("middraw_done",     32'(done),       32'd0);
         chk("middraw_rom_addr", 32'(rom_addr),   32'd0);
         exp_q.delete();
         @(negedge clk);
         reset = 1'b1;
      end
      render(200, "after_reset");

      transp_on = 1'b1;
      for (int r = 0; r < 8; r++) begin
         int tr, row, col, pct;
         tr       = int'($urandom_range(0, 479));
         rom_seed = 16'($urandom);
         pct      = (r < 4) ? 15 : 60;
         for (int i = 0; i < N; i++) begin
            row = tr - int'($urandom_range(0, 40));
            if (row < 0) row = 0;
            if ($urandom_range(0, 3) == 0) row = int'($urandom_range(0, 511));
            case ($urandom_range(0, 3))
               0:       col = int'($urandom_range(600, 639));
               1:       col = int'($urandom_range(0, 1023));
               default: col = int'($urandom_range(0, 639));
            endcase
            wr_attr(i, mk_attr(int'($urandom_range(0, 99)) < pct,
                               1'($urandom), 1'($urandom), 1'($urandom),
                               row, col, int'($urandom_range(0, 255))));
         end
         render(tr, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
